riscv_apu_disp_fifo: RTL and testbench

RISCV_APU_DISP_FIFO -- requirements
Module: riscv_apu_disp_fifo

---
 rtl/riscv_apu_disp_fifo.sv | 207 ++++++++++++++++++++
 tb/tb_riscv_apu_disp_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_apu_disp_fifo.sv
// APU dispatcher: in-order FIFO of outstanding APU destination registers,
// with stall generation, result bypass and register-hazard detection.
// Optional macro RISCV_APU_DISP_PERF_EN adds saturating stall-cycle counters.
module riscv_apu_disp_fifo #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned NRD    = 3,
    parameter int unsigned NWR    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      enable_i,
    input  logic [1:0]                apu_lat_i,
    input  logic [ADDR_W-1:0]         apu_waddr_i,
    output logic [ADDR_W-1:0]         apu_waddr_o,
    output logic                      apu_wvalid_o,
    output logic                      apu_multicycle_o,
    output logic                      apu_singlecycle_o,
    output logic                      active_o,
    output logic                      stall_o,
    input  logic [NRD*ADDR_W-1:0]     read_regs_i,
    input  logic [NRD-1:0]            read_regs_valid_i,
    output logic                      read_dep_o,
    input  logic [NWR*ADDR_W-1:0]     write_regs_i,
    input  logic [NWR-1:0]            write_regs_valid_i,
    output logic                      write_dep_o,
    output logic                      perf_type_o,
    output logic                      perf_cont_o,
`ifdef RISCV_APU_DISP_PERF_EN
    output logic [15:0]               perf_full_cnt_o,
    output logic [15:0]               perf_type_cnt_o,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                      err_o,
    output logic                      apu_master_req_o,
    output logic                      apu_master_ready_o,
    input  logic                      apu_master_gnt_i,
    input  logic                      apu_master_valid_i
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic [1:0]        last_lat_q;
    logic              err_q;

    logic              active;
    logic              stall_full;
    logic              stall_type;
    logic              stall_nack;
    logic              valid_req;
    logic              bypass;
    logic              push;
    logic              pop;
    logic              orphan;
    logic [DEPTH-1:0]  entry_live;
    logic              read_dep;
    logic              write_dep;

    // Wrap a FIFO pointer modulo DEPTH (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Request qualification, stall sources, push/pop/bypass decode.
    always_comb begin
        active     = (count_q != '0);
        stall_full = (count_q == CNT_W'(DEPTH)) && !apu_master_valid_i;
        stall_type = enable_i && active &&
                     ((apu_lat_i == 2'd1) || (apu_lat_i == 2'd3) ||
                      ((apu_lat_i == 2'd2) && (last_lat_q == 2'd3)));
        valid_req  = enable_i && !stall_full && !stall_type;
        stall_nack = valid_req && !apu_master_gnt_i;
        bypass     = !active && valid_req && apu_master_gnt_i && apu_master_valid_i;
        pop        = apu_master_valid_i && active;
        push       = valid_req && apu_master_gnt_i && !bypass;
        orphan     = apu_master_valid_i && !active && !bypass;
    end

    // Entries still outstanding after this cycle's pop.
    always_comb begin
        entry_live = valid_q;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (pop && (head_q == PTR_W'(e))) begin
                entry_live[e] = 1'b0;
            end
        end
    end

    // Hazard compare: new un-bypassed request plus every live entry.
    always_comb begin
        read_dep  = 1'b0;
        write_dep = 1'b0;
        for (int unsigned p = 0; p < NRD; p++) begin
            if (read_regs_valid_i[p]) begin
                if (valid_req && !bypass &&
                    (read_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i)) begin
                    read_dep = 1'b1;
                end
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (entry_live[e] && (addr_q[e] == read_regs_i[p*ADDR_W +: ADDR_W])) begin
                        read_dep = 1'b1;
                    end
                end
            end
        end
        for (int unsigned p = 0; p < NWR; p++) begin
            if (write_regs_valid_i[p]) begin
                if (valid_req && !bypass &&
                    (write_regs_i[p*ADDR_W +: ADDR_W] == apu_waddr_i)) begin
                    write_dep = 1'b1;
                end
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    if (entry_live[e] && (addr_q[e] == write_regs_i[p*ADDR_W +: ADDR_W])) begin
                        write_dep = 1'b1;
                    end
                end
            end
        end
    end

    // FIFO storage, pointers, occupancy, last latency class and sticky error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                addr_q[e] <= '0;
            end
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            last_lat_q <= 2'd0;
            err_q      <= 1'b0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= ptr_inc(head_q);
            end
            // Set after clear so a full-FIFO pop+push on the same slot stays valid.
            if (push) begin
                addr_q[tail_q]  <= apu_waddr_i;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= ptr_inc(tail_q);
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (valid_req) begin
                last_lat_q <= apu_lat_i;
            end
            if (orphan) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef RISCV_APU_DISP_PERF_EN
    logic [15:0] perf_full_q;
    logic [15:0] perf_type_q;

    // Saturating stall-cycle counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_full_q <= '0;
            perf_type_q <= '0;
        end else begin
            if (stall_full && (perf_full_q != 16'hFFFF)) begin
                perf_full_q <= perf_full_q + 16'd1;
            end
            if (stall_type && (perf_type_q != 16'hFFFF)) begin
                perf_type_q <= perf_type_q + 16'd1;
            end
        end
    end

    assign perf_full_cnt_o = perf_full_q;
    assign perf_type_cnt_o = perf_type_q;
`endif

    // Result return path: bypass of the new op, else the popped head.
    always_comb begin
        apu_waddr_o = '0;
        if (bypass) begin
            apu_waddr_o = apu_waddr_i;
        end else if (pop) begin
            apu_waddr_o = addr_q[head_q];
        end
    end

    assign apu_wvalid_o       = bypass || pop;
    assign apu_multicycle_o   = (last_lat_q == 2'd3);
    assign apu_singlecycle_o  = !active;
    assign active_o           = active;
    assign stall_o            = stall_full || stall_type || stall_nack;
    assign read_dep_o         = read_dep;
    assign write_dep_o        = write_dep;
    assign perf_type_o        = stall_type;
    assign perf_cont_o        = stall_nack;
    assign count_o            = count_q;
    assign err_o              = err_q;
    assign apu_master_req_o   = valid_req;
    assign apu_master_ready_o = 1'b1;

endmodule

// File: tb/tb_riscv_apu_disp_fifo.sv
// Scoreboard bench: DEPTH=2 instance for stall/bypass/hazard/error cases,
// DEPTH=4 instance for in-order return across pointer wrap.
module tb_riscv_apu_disp_fifo;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    logic [5:0] exp_q2 [$];
    logic [5:0] exp_q4 [$];

    // DEPTH=2 instance signals
    logic        en2, gnt2, val2;
    logic [1:0]  lat2;
    logic [5:0]  wa2_in, wa2_out;
    logic        wv2, mc2, sc2, act2, stall2, rdep2, wdep2, ptype2, pcont2, err2, req2, rdy2;
    logic [17:0] rregs2;
    logic [2:0]  rval2;
    logic [11:0] wregs2;
    logic [1:0]  wval2;
    logic [1:0]  cnt2;

    // DEPTH=4 instance signals
    logic        en4, gnt4, val4;
    logic [5:0]  wa4_in, wa4_out;
    logic        wv4, mc4, sc4, act4, stall4, rdep4, wdep4, ptype4, pcont4, err4, req4, rdy4;
    logic [2:0]  cnt4;

    riscv_apu_disp_fifo #(.ADDR_W(6), .DEPTH(2), .NRD(3), .NWR(2)) u_d2 (
        .clk_i(clk), .rst_i(rst), .enable_i(en2), .apu_lat_i(lat2),
        .apu_waddr_i(wa2_in), .apu_waddr_o(wa2_out), .apu_wvalid_o(wv2),
        .apu_multicycle_o(mc2), .apu_singlecycle_o(sc2), .active_o(act2),
        .stall_o(stall2), .read_regs_i(rregs2), .read_regs_valid_i(rval2),
        .read_dep_o(rdep2), .write_regs_i(wregs2), .write_regs_valid_i(wval2),
        .write_dep_o(wdep2), .perf_type_o(ptype2), .perf_cont_o(pcont2),
        .count_o(cnt2), .err_o(err2), .apu_master_req_o(req2),
        .apu_master_ready_o(rdy2), .apu_master_gnt_i(gnt2), .apu_master_valid_i(val2)
    );

    riscv_apu_disp_fifo #(.ADDR_W(6), .DEPTH(4), .NRD(3), .NWR(2)) u_d4 (
        .clk_i(clk), .rst_i(rst), .enable_i(en4), .apu_lat_i(2'd0),
        .apu_waddr_i(wa4_in), .apu_waddr_o(wa4_out), .apu_wvalid_o(wv4),
        .apu_multicycle_o(mc4), .apu_singlecycle_o(sc4), .active_o(act4),
        .stall_o(stall4), .read_regs_i(18'd0), .read_regs_valid_i(3'd0),
        .read_dep_o(rdep4), .write_regs_i(12'd0), .write_regs_valid_i(2'd0),
        .write_dep_o(wdep4), .perf_type_o(ptype4), .perf_cont_o(pcont4),
        .count_o(cnt4), .err_o(err4), .apu_master_req_o(req4),
        .apu_master_ready_o(rdy4), .apu_master_gnt_i(gnt4), .apu_master_valid_i(val4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every returned result is compared with the oldest expected address.
    always @(negedge clk) begin
        if (wv2 === 1'b1) begin
            if (exp_q2.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL ret2_unexpected: got addr %0d expected no return", wa2_out);
            end else begin
                chk("ret2_addr", 32'(wa2_out), 32'(exp_q2.pop_front()));
            end
        end
        if (wv4 === 1'b1) begin
            if (exp_q4.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL ret4_unexpected: got addr %0d expected no return", wa4_out);
            end else begin
                chk("ret4_addr", 32'(wa4_out), 32'(exp_q4.pop_front()));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus; expected returns are pushed as requests are accepted.
    initial begin
        rst = 1'b1;
        en2 = 0; gnt2 = 0; val2 = 0; lat2 = 2'd0; wa2_in = '0;
        rregs2 = '0; rval2 = '0; wregs2 = '0; wval2 = '0;
        en4 = 0; gnt4 = 0; val4 = 0; wa4_in = '0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_count", 32'(cnt2), 0);
        chk("rst_single", 32'(sc2), 1);
        chk("rst_ready", 32'(rdy2), 1);
        chk("rst_active", 32'(act2), 0);
        chk("rst_stall", 32'(stall2), 0);
        chk("rst_err", 32'(err2), 0);
        chk("rst_wvalid", 32'(wv2), 0);
        chk("rst_waddr", 32'(wa2_out), 0);
        chk("rst_multi", 32'(mc2), 0);
        chk("rst_req", 32'(req2), 0);
        next_cycle();
        rst = 1'b0;

        // DEPTH=4: 8 pushes and 8 pops interleaved, wrapping the pointers
        for (int k = 0; k < 3; k++) begin
            en4 = 1; gnt4 = 1; val4 = 0; wa4_in = 6'(20 + k);
            exp_q4.push_back(6'(20 + k));
            next_cycle();
        end
        en4 = 0;
        @(negedge clk);
        chk("d4_count3", 32'(cnt4), 3);
        next_cycle();
        for (int k = 3; k < 8; k++) begin
            en4 = 1; gnt4 = 1; val4 = 1; wa4_in = 6'(20 + k);
            exp_q4.push_back(6'(20 + k));
            @(negedge clk);
            chk("d4_stall", 32'(stall4), 0);
            chk("d4_count_steady", 32'(cnt4), 3);
            next_cycle();
        end
        en4 = 0;
        for (int k = 0; k < 3; k++) begin
            val4 = 1;
            next_cycle();
        end
        val4 = 0;
        @(negedge clk);
        chk("d4_count_end", 32'(cnt4), 0);
        chk("d4_drained", 32'(exp_q4.size()), 0);
        next_cycle();

        // DEPTH=2: fill to full
        en2 = 1; gnt2 = 1; wa2_in = 6'd5; exp_q2.push_back(6'd5);
        @(negedge clk);
        chk("c1_req", 32'(req2), 1);
        chk("c1_stall", 32'(stall2), 0);
        next_cycle();
        wa2_in = 6'd9; exp_q2.push_back(6'd9);
        @(negedge clk);
        chk("c2_count", 32'(cnt2), 1);
        next_cycle();
        wa2_in = 6'd12;
        @(negedge clk);
        chk("full_count", 32'(cnt2), 2);
        chk("full_stall", 32'(stall2), 1);
        chk("full_req", 32'(req2), 0);
        chk("full_ptype", 32'(ptype2), 0);
        next_cycle();
        // full + returning result frees a slot the same cycle
        val2 = 1; exp_q2.push_back(6'd12);
        @(negedge clk);
        chk("fullpop_stall", 32'(stall2), 0);
        chk("fullpop_req", 32'(req2), 1);
        chk("fullpop_wvalid", 32'(wv2), 1);
        next_cycle();
        en2 = 0; val2 = 0; rregs2 = {6'd0, 6'd9, 6'd0}; rval2 = 3'b010;
        @(negedge clk);
        chk("fullpop_count", 32'(cnt2), 2);
        chk("rdep_outstanding", 32'(rdep2), 1);
        chk("wdep_none", 32'(wdep2), 0);
        next_cycle();
        // popping entry no longer a read hazard; other entry is a write hazard
        val2 = 1; wregs2 = {6'd0, 6'd12}; wval2 = 2'b01;
        @(negedge clk);
        chk("rdep_popping", 32'(rdep2), 0);
        chk("wdep_outstanding", 32'(wdep2), 1);
        next_cycle();
        rval2 = '0; wval2 = '0;
        @(negedge clk);
        chk("c7_count", 32'(cnt2), 1);
        next_cycle();
        // hazard on entry 3 from issue through return
        val2 = 0; en2 = 1; gnt2 = 1; wa2_in = 6'd3;
        rregs2 = {6'd0, 6'd3, 6'd0}; rval2 = 3'b010; exp_q2.push_back(6'd3);
        @(negedge clk);
        chk("c8_count", 32'(cnt2), 0);
        chk("rdep_newreq", 32'(rdep2), 1);
        next_cycle();
        en2 = 0;
        @(negedge clk);
        chk("rdep_entry3", 32'(rdep2), 1);
        chk("c9_active", 32'(act2), 1);
        chk("c9_single", 32'(sc2), 0);
        next_cycle();
        val2 = 1;
        @(negedge clk);
        chk("rdep_ret3", 32'(rdep2), 0);
        next_cycle();
        // bypass on empty FIFO
        en2 = 1; gnt2 = 1; val2 = 1; wa2_in = 6'd7;
        rregs2 = {6'd0, 6'd7, 6'd0}; exp_q2.push_back(6'd7);
        @(negedge clk);
        chk("byp_wvalid", 32'(wv2), 1);
        chk("byp_waddr", 32'(wa2_out), 7);
        chk("byp_rdep", 32'(rdep2), 0);
        next_cycle();
        // grant refused: nack stall, last_lat still loads
        val2 = 0; rval2 = '0; gnt2 = 0; lat2 = 2'd3; wa2_in = 6'd4;
        @(negedge clk);
        chk("byp_count", 32'(cnt2), 0);
        chk("nack_stall", 32'(stall2), 1);
        chk("nack_pcont", 32'(pcont2), 1);
        chk("nack_req", 32'(req2), 1);
        next_cycle();
        gnt2 = 1; lat2 = 2'd0; wa2_in = 6'd6; exp_q2.push_back(6'd6);
        @(negedge clk);
        chk("lat3_multi", 32'(mc2), 1);
        chk("c13_stall", 32'(stall2), 0);
        next_cycle();
        lat2 = 2'd1; wa2_in = 6'd8;
        @(negedge clk);
        chk("c14_count", 32'(cnt2), 1);
        chk("c14_multi", 32'(mc2), 0);
        chk("type1_stall", 32'(stall2), 1);
        chk("type1_ptype", 32'(ptype2), 1);
        chk("type1_req", 32'(req2), 0);
        next_cycle();
        en2 = 0; val2 = 1;
        next_cycle();
        val2 = 0; en2 = 1; lat2 = 2'd3; wa2_in = 6'd10; exp_q2.push_back(6'd10);
        @(negedge clk);
        chk("c16_count", 32'(cnt2), 0);
        chk("c16_stall", 32'(stall2), 0);
        next_cycle();
        lat2 = 2'd2; wa2_in = 6'd11;
        @(negedge clk);
        chk("type2_stall", 32'(stall2), 1);
        chk("type2_ptype", 32'(ptype2), 1);
        next_cycle();
        en2 = 0; lat2 = 2'd0; val2 = 1;
        next_cycle();
        // result with nothing outstanding -> sticky error
        @(negedge clk);
        chk("orphan_wvalid", 32'(wv2), 0);
        chk("orphan_err_pre", 32'(err2), 0);
        next_cycle();
        val2 = 0; en2 = 1; wa2_in = 6'd11; exp_q2.push_back(6'd11);
        @(negedge clk);
        chk("err_set", 32'(err2), 1);
        next_cycle();
        en2 = 0; val2 = 1;
        @(negedge clk);
        chk("err_held", 32'(err2), 1);
        next_cycle();
        // reset with an op outstanding discards it
        val2 = 0; en2 = 1; wa2_in = 6'd13;
        next_cycle();
        en2 = 0;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", 32'(cnt2), 0);
        chk("arst_err", 32'(err2), 0);
        chk("arst_active", 32'(act2), 0);
        next_cycle();
        rst = 1'b0;
        val2 = 1;
        @(negedge clk);
        chk("post_rst_wvalid", 32'(wv2), 0);
        next_cycle();
        val2 = 0;
        @(negedge clk);
        chk("post_rst_err", 32'(err2), 1);
        chk("d2_drained", 32'(exp_q2.size()), 0);
        next_cycle();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
